// File: rtl/dropout_pkg.sv
// rtl/dropout_pkg.sv - shared constants, state encoding and helpers for the dropout stages
package dropout_pkg;

  localparam int DATA_W = 8;
  localparam int LFSR_W = 2 * DATA_W;

  // Galois taps x^16+x^14+x^13+x^11+1; transmitter and receiver must agree
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  // Substituted for an all-zero seed, which would lock the LFSR at zero
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOST = 2'd2
  } state_t;

  // One Galois step; operands are zero-extended so any width up to 32 works
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'd0);
  endfunction

  // Number of set bits in a zero-extended vector
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dropout_lfsr.sv
// rtl/dropout_lfsr.sv - loadable Galois LFSR shared by both ends of the dropout link
module dropout_lfsr #(
  parameter int           W        = dropout_pkg::LFSR_W,
  parameter logic [W-1:0] TAPS     = dropout_pkg::LFSR_TAPS,
  parameter logic [W-1:0] SEED_DEF = dropout_pkg::SEED_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_seed,
  output logic [W-1:0] o_lfsr
);
  import dropout_pkg::*;

  logic [W-1:0] r_lfsr;
  logic [W-1:0] w_next;

  // Next LFSR value through the shared step function
  always_comb begin
    w_next = W'(lfsr_next(32'(r_lfsr), 32'(TAPS)));
  end

  // Load has priority over step; a zero seed falls back to the default
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED_DEF;
    end else if (i_load) begin
      r_lfsr <= (i_seed == '0) ? SEED_DEF : i_seed;
    end else if (i_step) begin
      r_lfsr <= w_next;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/dropout_restore.sv
// rtl/dropout_restore.sv - receive-side dropout mask regeneration with sample-and-hold fill
module dropout_restore #(
  parameter int                   WIDTH        = dropout_pkg::DATA_W,
  parameter logic [2*WIDTH-1:0]   LFSR_TAPS    = dropout_pkg::LFSR_TAPS,
  parameter logic [2*WIDTH-1:0]   SEED_DEFAULT = dropout_pkg::SEED_DEFAULT,
  parameter int unsigned          ERR_LIMIT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ena,
  input  logic                 i_seed_load,
  input  logic [2*WIDTH-1:0]   i_seed,
  input  logic                 i_valid_in,
  input  logic [WIDTH-1:0]     i_datain,
  output logic [WIDTH-1:0]     o_dataout,
  output logic                 o_valid_out,
  output logic [WIDTH-1:0]     o_mask_out,
  output logic [15:0]          o_drop_count,
  output logic                 o_sync_err
);
  import dropout_pkg::*;

  localparam int LW = 2 * WIDTH;

  state_t           r_state, w_state_nxt;
  logic [LW-1:0]    w_lfsr;
  logic [WIDTH-1:0] w_mask, w_restored;
  logic [WIDTH-1:0] r_held, r_dataout, r_mask_out;
  logic             r_valid_out;
  logic [15:0]      r_drop_count, w_drop_nxt;
  logic [16:0]      w_drop_sum;
  logic [7:0]       r_err_cnt, w_err_nxt;
  logic [8:0]       w_err_sum;
  logic             w_load, w_accept;

  // A seed load on the same edge as a word discards the word
  assign w_load   = i_ena & i_seed_load;
  assign w_accept = i_ena & ~i_seed_load & i_valid_in & (r_state != IDLE);

  // Both halves of the LFSR must be 1 for a bit to be dropped (~1/4 density)
  assign w_mask     = w_lfsr[WIDTH-1:0] & w_lfsr[LW-1:WIDTH];
  assign w_restored = (i_datain & ~w_mask) | (r_held & w_mask);

  assign w_drop_sum = {1'b0, r_drop_count} + 17'(popcount(32'(w_mask)));
  assign w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  // A 1 in a dropped position means our mask no longer matches the transmitter's
  assign w_err_sum = {1'b0, r_err_cnt} + 9'(popcount(32'(i_datain & w_mask)));
  assign w_err_nxt = w_accept ? (w_err_sum[8] ? 8'hFF : w_err_sum[7:0]) : r_err_cnt;

  dropout_lfsr #(
    .W        (LW),
    .TAPS     (LFSR_TAPS),
    .SEED_DEF (SEED_DEFAULT)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_accept),
    .i_seed (i_seed),
    .o_lfsr (w_lfsr)
  );

  // Sync state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Seed load always resyncs; RUN drops to LOST on the edge the error count reaches the limit
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = RUN;
    end else if ((r_state == RUN) && (32'(w_err_nxt) >= ERR_LIMIT)) begin
      w_state_nxt = LOST;
    end
  end

  // Data path: restore accepted words, clear history on seed load, freeze when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held       <= '0;
      r_dataout    <= '0;
      r_mask_out   <= '0;
      r_valid_out  <= 1'b0;
      r_drop_count <= '0;
      r_err_cnt    <= '0;
    end else if (!i_ena) begin
      r_valid_out  <= 1'b0;
    end else if (i_seed_load) begin
      r_held       <= '0;
      r_valid_out  <= 1'b0;
      r_drop_count <= '0;
      r_err_cnt    <= '0;
    end else if (w_accept) begin
      r_held       <= w_restored;
      r_dataout    <= w_restored;
      r_mask_out   <= w_mask;
      r_valid_out  <= 1'b1;
      r_drop_count <= w_drop_nxt;
      r_err_cnt    <= w_err_nxt;
    end else begin
      r_valid_out  <= 1'b0;
    end
  end

  assign o_dataout    = r_dataout;
  assign o_valid_out  = r_valid_out;
  assign o_mask_out   = r_mask_out;
  assign o_drop_count = r_drop_count;
  assign o_sync_err   = (r_state == LOST);

endmodule
